// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces an active-low push-button into a level, press/release/long pulses and a press tally
module btn_conditioner #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1500000,
    parameter logic [23:0] LONG_CYCLES     = 24'd15000000
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       btn_n,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    state_t      state, state_d;
    logic        s1, b_s;
    logic [23:0] stab_cnt, stab_d, hold_cnt, hold_d;
    logic        long_fired, fired_d;
    logic        press_d, release_d, long_d;
    logic [7:0]  count_d;
    // two-flop synchronizer on the inverted pin so downstream logic sees active-high
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            s1  <= 1'b0;
            b_s <= 1'b0;
        end else begin
            s1  <= ~btn_n;
            b_s <= s1;
        end
    end
    // next-state and registered-output values; hold_cnt only advances while PRESSED
    always_comb begin
        state_d   = state;
        stab_d    = stab_cnt;
        hold_d    = hold_cnt;
        fired_d   = long_fired;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        count_d   = press_count;
        case (state)
            IDLE: begin
                if (b_s) begin
                    state_d = PRESS_WAIT;
                    stab_d  = 24'd1;
                end
            end
            PRESS_WAIT: begin
                if (!b_s) begin
                    state_d = IDLE;
                    stab_d  = 24'd0;
                end else if (stab_cnt == DEBOUNCE_CYCLES - 24'd1) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    count_d = press_count + 8'd1;
                    hold_d  = 24'd0;
                end else begin
                    stab_d = stab_cnt + 24'd1;
                end
            end
            PRESSED: begin
                hold_d = (hold_cnt == LONG_CYCLES) ? hold_cnt : hold_cnt + 24'd1;
                if (hold_cnt == LONG_CYCLES - 24'd1 && !long_fired) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
                if (!b_s) begin
                    state_d = RELEASE_WAIT;
                    stab_d  = 24'd1;
                end
            end
            RELEASE_WAIT: begin
                if (b_s) begin
                    state_d = PRESSED;
                    stab_d  = 24'd0;
                end else if (stab_cnt == DEBOUNCE_CYCLES - 24'd1) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    fired_d   = 1'b0;
                end else begin
                    stab_d = stab_cnt + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state, counters and all outputs registered together
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state         <= IDLE;
            stab_cnt      <= 24'd0;
            hold_cnt      <= 24'd0;
            long_fired    <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_d;
            stab_cnt      <= stab_d;
            hold_cnt      <= hold_d;
            long_fired    <= fired_d;
            btn_level     <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            press_count   <= count_d;
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner with short debounce/long windows
module tb_btn_conditioner;
    localparam int DC = 4;
    localparam int LC = 20;
    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] cnt;
        logic       lvl;
    } ev_t;
    logic       clk, rst_btn, btn_n;
    logic       btn_level, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_count = 8'd0;
    ev_t        q[$];
    btn_conditioner #(
        .DEBOUNCE_CYCLES(24'(DC)),
        .LONG_CYCLES    (24'(LC))
    ) dut (
        .clk          (clk),
        .rst_btn      (rst_btn),
        .btn_n        (btn_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // scoreboard: every pulse must match the next expected event exactly in kind, cycle, tally and level
    always @(negedge clk) begin
        if (rst_btn && (press_pulse || release_pulse || long_pulse)) begin
            int  k;
            ev_t e;
            tests++;
            k = press_pulse ? 0 : release_pulse ? 1 : 2;
            if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) != 1) begin
                fails++;
                $display("FAIL exclusive: press=%0b release=%0b long=%0b at cycle %0d, required one-hot", press_pulse, release_pulse, long_pulse, cyc);
            end else if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", k, cyc);
            end else begin
                e = q.pop_front();
                if (k !== e.kind || cyc !== e.cyc || press_count !== e.cnt || btn_level !== e.lvl) begin
                    fails++;
                    $display("FAIL pulse: kind=%0d cyc=%0d count=%0d level=%0b, required kind=%0d cyc=%0d count=%0d level=%0b", k, cyc, press_count, btn_level, e.kind, e.cyc, e.cnt, e.lvl);
                end
            end
        end
    end
    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d events pending, required 0", name, q.size());
            q.delete();
        end
    endtask
    task automatic press_release(input int h, input int gap);
        int d, r;
        @(negedge clk);
        d = cyc;
        btn_n = 1'b0;
        exp_count++;
        q.push_back('{0, d + DC + 2, exp_count, 1'b1});
        if (h >= LC + 3) q.push_back('{2, d + DC + 2 + LC, exp_count, 1'b1});
        repeat (h) @(negedge clk);
        r = cyc;
        btn_n = 1'b1;
        q.push_back('{1, r + DC + 2, exp_count, 1'b0});
        repeat (gap) @(negedge clk);
    endtask
    task automatic test_reset();
        rst_btn = 1'b0;
        btn_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_n = ~btn_n;
            tests++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
                fails++;
                $display("FAIL reset_hold: outputs=%h, required 0", {btn_level, press_pulse, release_pulse, long_pulse, press_count});
            end
        end
        btn_n = 1'b1;
        @(negedge clk);
        rst_btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tests++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
                fails++;
                $display("FAIL reset_idle: outputs=%h, required 0", {btn_level, press_pulse, release_pulse, long_pulse, press_count});
            end
        end
    endtask
    task automatic test_bounce();
        @(negedge clk);
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
        repeat (2) @(negedge clk);
        btn_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_n = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (btn_level !== 1'b0 || press_count !== 8'd0) begin
            fails++;
            $display("FAIL bounce: level=%0b count=%0d, required level=0 count=0", btn_level, press_count);
        end
    endtask
    task automatic test_clean();
        press_release(15, 10);
        drain("clean");
        tests++;
        if (btn_level !== 1'b0 || press_count !== 8'd1) begin
            fails++;
            $display("FAIL clean_end: level=%0b count=%0d, required level=0 count=1", btn_level, press_count);
        end
    endtask
    task automatic test_long();
        press_release(60, 10);
        press_release(60, 10);
        drain("long");
    endtask
    task automatic test_release_bounce();
        int d, r;
        @(negedge clk);
        d = cyc;
        btn_n = 1'b0;
        exp_count++;
        q.push_back('{0, d + DC + 2, exp_count, 1'b1});
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        btn_n = 1'b0;
        q.push_back('{2, d + DC + 2 + LC + 3, exp_count, 1'b1});
        repeat (30) @(negedge clk);
        r = cyc;
        btn_n = 1'b1;
        q.push_back('{1, r + DC + 2, exp_count, 1'b0});
        repeat (10) @(negedge clk);
        drain("release_bounce");
    endtask
    task automatic test_mid_reset();
        int c;
        @(negedge clk);
        c = cyc;
        btn_n = 1'b0;
        exp_count++;
        q.push_back('{0, c + DC + 2, exp_count, 1'b1});
        repeat (10) @(negedge clk);
        drain("mid_reset_press");
        rst_btn = 1'b0;
        #1;
        tests++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
            fails++;
            $display("FAIL mid_reset_clear: outputs=%h, required 0", {btn_level, press_pulse, release_pulse, long_pulse, press_count});
        end
        exp_count = 8'd0;
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        c = cyc;
        exp_count++;
        q.push_back('{0, c + DC + 2, exp_count, 1'b1});
        repeat (12) @(negedge clk);
        c = cyc;
        btn_n = 1'b1;
        q.push_back('{1, c + DC + 2, exp_count, 1'b0});
        drain("mid_reset");
        tests++;
        if (press_count !== 8'd1) begin
            fails++;
            $display("FAIL mid_reset_count: count=%0d, required 1", press_count);
        end
    endtask
    task automatic test_wrap();
        @(negedge clk);
        rst_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_btn = 1'b1;
        exp_count = 8'd0;
        for (int i = 0; i < 256; i++) press_release(8, 8);
        drain("wrap");
        tests++;
        if (press_count !== 8'd0) begin
            fails++;
            $display("FAIL wrap: count=%0d, required 0", press_count);
        end
    endtask
    initial begin
        test_reset();
        test_bounce();
        test_clean();
        test_long();
        test_release_bounce();
        test_mid_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
